// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_if
// Description : Bundle of the pipeline request/response handshake and the
//               data-memory port around the load/store unit.
//               master = environment (pipeline + memory), slave = lsu_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Request side
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [1:0]        req_op;
    logic              req_ext;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    // Response side
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    // Memory port
    logic              mem_wr;
    logic [1:0]        mem_op;
    logic              mem_ext;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req_valid, req_wr, req_op, req_ext, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_wr, mem_op, mem_ext, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_wr, req_op, req_ext, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_wr, mem_op, mem_ext, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store initiator between the pipeline memory stage and a
//               byte-addressed data memory. One request in flight, sequenced
//               IDLE -> ACCESS -> RESP -> IDLE, one-cycle response pulse.
//               Build option LSU_MISALIGN_SPLIT_EN: when defined, misaligned
//               half/word accesses are split into sequential byte accesses;
//               when undefined they are rejected with resp_err.
// Revision    : 1.0  initial release
// ============================================================================
module lsu_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    lsu_ctrl_if.slave lsu
);

    // FSM encoding
    localparam logic [1:0] c_st_idle   = 2'b00;
    localparam logic [1:0] c_st_access = 2'b01;
    localparam logic [1:0] c_st_resp   = 2'b10;

    // Memory size op encoding
    localparam logic [1:0] c_mem_byte = 2'b00;
    localparam logic [1:0] c_mem_half = 2'b01;
    localparam logic [1:0] c_mem_word = 2'b10;
    localparam logic [1:0] c_mem_bad  = 2'b11;

    logic [1:0]        r_state;

    // Registered memory port; these hold their last value outside ACCESS
    logic              r_mem_wr;
    logic [1:0]        r_mem_op;
    logic              r_mem_ext;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    // Response registers
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;

    logic              w_misaligned;
    logic              w_illegal;

`ifdef LSU_MISALIGN_SPLIT_EN
    // Split-access bookkeeping
    logic              r_split;
    logic [1:0]        r_cnt;
    logic [1:0]        r_last;
    logic              r_split_ext;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_acc;

    logic [1:0]        w_cnt_nxt;
    logic [7:0]        w_next_byte;
    logic [DATA_W-1:0] w_acc_next;
    logic [DATA_W-1:0] w_split_result;
`endif

    // Classify the incoming request by size and low address bits
    always_comb begin
        w_illegal = (lsu.req_op == c_mem_bad);
        case (lsu.req_op)
            c_mem_half: w_misaligned = lsu.req_addr[0];
            c_mem_word: w_misaligned = |lsu.req_addr[1:0];
            default:    w_misaligned = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // Merge this cycle's byte into the partial load and select the next store byte
    always_comb begin
        w_cnt_nxt  = r_cnt + 2'd1;
        w_acc_next = r_acc;
        case (r_cnt)
            2'd0:    w_acc_next[7:0]   = lsu.mem_rdata[7:0];
            2'd1:    w_acc_next[15:8]  = lsu.mem_rdata[7:0];
            2'd2:    w_acc_next[23:16] = lsu.mem_rdata[7:0];
            default: w_acc_next[31:24] = lsu.mem_rdata[7:0];
        endcase
        case (w_cnt_nxt)
            2'd1:    w_next_byte = r_wdata[15:8];
            2'd2:    w_next_byte = r_wdata[23:16];
            2'd3:    w_next_byte = r_wdata[31:24];
            default: w_next_byte = r_wdata[7:0];
        endcase
        // Two-byte splits are halfwords and get extended from bit 15
        if (r_last == 2'd1) begin
            w_split_result = r_split_ext ? {{16{w_acc_next[15]}}, w_acc_next[15:0]}
                                         : {16'h0000, w_acc_next[15:0]};
        end else begin
            w_split_result = w_acc_next;
        end
    end
`endif

    // Request sequencing, memory port drive and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_mem_wr     <= 1'b0;
            r_mem_op     <= 2'b00;
            r_mem_ext    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_split      <= 1'b0;
            r_cnt        <= 2'd0;
            r_last       <= 2'd0;
            r_split_ext  <= 1'b0;
            r_wdata      <= '0;
            r_acc        <= '0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (lsu.req_valid) begin
                        if (w_illegal) begin
                            // Unused size encoding: answer with an error, no memory access
                            r_state      <= c_st_resp;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (w_misaligned) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                            r_state     <= c_st_access;
                            r_split     <= 1'b1;
                            r_cnt       <= 2'd0;
                            r_last      <= (lsu.req_op == c_mem_half) ? 2'd1 : 2'd3;
                            r_split_ext <= lsu.req_ext;
                            r_wdata     <= lsu.req_wdata;
                            r_acc       <= '0;
                            r_mem_wr    <= lsu.req_wr;
                            r_mem_op    <= c_mem_byte;
                            r_mem_ext   <= 1'b0;
                            r_mem_addr  <= lsu.req_addr;
                            r_mem_wdata <= {{(DATA_W-8){1'b0}}, lsu.req_wdata[7:0]};
`else
                            r_state      <= c_st_resp;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
`endif
                        end else begin
                            r_state     <= c_st_access;
`ifdef LSU_MISALIGN_SPLIT_EN
                            r_split     <= 1'b0;
`endif
                            r_mem_wr    <= lsu.req_wr;
                            r_mem_op    <= lsu.req_op;
                            r_mem_ext   <= lsu.req_ext;
                            r_mem_addr  <= lsu.req_addr;
                            r_mem_wdata <= lsu.req_wdata;
                        end
                    end
                end

                c_st_access: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (r_split) begin
                        r_acc <= w_acc_next;
                        if (r_cnt == r_last) begin
                            r_state      <= c_st_resp;
                            r_mem_wr     <= 1'b0;
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= r_mem_wr ? '0 : w_split_result;
                        end else begin
                            r_cnt       <= w_cnt_nxt;
                            r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                            r_mem_wdata <= {{(DATA_W-8){1'b0}}, w_next_byte};
                        end
                    end else
`endif
                    begin
                        // Single aligned access: memory already extends the load
                        r_state      <= c_st_resp;
                        r_mem_wr     <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_mem_wr ? '0 : lsu.mem_rdata;
                    end
                end

                c_st_resp: begin
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state  <= c_st_idle;
                    r_mem_wr <= 1'b0;
                end
            endcase
        end
    end

    assign lsu.req_ready  = (r_state == c_st_idle);
    assign lsu.resp_valid = (r_state == c_st_resp);
    assign lsu.resp_rdata = r_resp_rdata;
    assign lsu.resp_err   = r_resp_err;
    assign lsu.mem_wr     = r_mem_wr;
    assign lsu.mem_op     = r_mem_op;
    assign lsu.mem_ext    = r_mem_ext;
    assign lsu.mem_addr   = r_mem_addr;
    assign lsu.mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Self-checking bench for lsu_ctrl. A transaction-level model
//               predicts every cycle of each request (memory port activity,
//               response pulse, ready) against a reference byte memory; a
//               single compare process checks the DUT each negedge. Directed
//               literal checks pin the model. Honours LSU_MISALIGN_SPLIT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

    logic clk;
    logic rst;

    lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .lsu (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
        logic        mwr;
        logic        chk_mem;
        logic [31:0] maddr;
        logic [1:0]  mop;
        logic        mext;
        logic [31:0] mwdata;
    } exp_t;

    exp_t expq[$];

    logic [7:0] dmem    [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    int          n_chk;
    int          n_err;
    int          wr_cycles;
    int          resp_cnt;
    logic [31:0] last_rdata;
    logic        last_err;

    logic        pend_wr;
    logic [31:0] pend_addr;
    logic [1:0]  pend_op;
    logic [31:0] pend_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_dm(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [1:0] op);
        return (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : 4;
    endfunction

    // Environment memory: combinational-style read refreshed every negedge,
    // writes captured at negedge and committed on the following rising edge
    always @(negedge clk) begin
        logic [31:0] v;
        int          n;
        pend_wr    = bus.mem_wr;
        pend_addr  = bus.mem_addr;
        pend_op    = bus.mem_op;
        pend_wdata = bus.mem_wdata;
        n = nbytes(bus.mem_op);
        v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(rd_dm(bus.mem_addr + 32'(k))) << (8 * k));
        if (bus.mem_ext && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (bus.mem_ext && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        bus.mem_rdata = v;
    end

    always @(posedge clk) begin
        if (pend_wr && !rst) begin
            for (int k = 0; k < nbytes(pend_op); k++)
                dmem[pend_addr + 32'(k)] = pend_wdata[8*k +: 8];
            pend_wr = 1'b0;
        end
    end

    // Single compare process: observe activity and check against the model
    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_wr) wr_cycles++;
        if (bus.resp_valid) begin
            resp_cnt++;
            last_rdata = bus.resp_rdata;
            last_err   = bus.resp_err;
        end
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("req_ready",  32'(bus.req_ready),  32'(e.ready));
            chk("resp_valid", 32'(bus.resp_valid), 32'(e.rv));
            chk("mem_wr",     32'(bus.mem_wr),     32'(e.mwr));
            if (e.chk_mem) begin
                chk("mem_addr",  bus.mem_addr,       e.maddr);
                chk("mem_op",    32'(bus.mem_op),    32'(e.mop));
                chk("mem_ext",   32'(bus.mem_ext),   32'(e.mext));
                chk("mem_wdata", bus.mem_wdata,      e.mwdata);
            end
            if (e.rv) begin
                chk("resp_err",   32'(bus.resp_err), 32'(e.err));
                chk("resp_rdata", bus.resp_rdata,    e.rdata);
            end
        end
    end

    // Transaction-level reference: derive every cycle of the request from the rules
    task automatic model(input bit wr, input logic [1:0] op, input bit ext,
                         input logic [31:0] addr, input logic [31:0] wd, output int n);
        exp_t        e;
        int          nb;
        bit          mis;
        bit          err;
        logic [31:0] val;
        nb  = nbytes(op);
        mis = (op == 2'd1 && addr[0]) || (op == 2'd2 && addr[1:0] != 2'b00);
        err = (op == 2'd3);
`ifndef LSU_MISALIGN_SPLIT_EN
        if (mis) err = 1'b1;
`endif
        n = 0;
        if (!err) begin
            val = 32'h0;
            for (int k = 0; k < nb; k++) val = val | (32'(rd_ref(addr + 32'(k))) << (8 * k));
            if (ext && nb == 1 && val[7])  val = val | 32'hFFFF_FF00;
            if (ext && nb == 2 && val[15]) val = val | 32'hFFFF_0000;
            if (!mis) begin
                e = '0;
                e.mwr = wr; e.chk_mem = 1'b1; e.maddr = addr; e.mop = op; e.mext = ext; e.mwdata = wd;
                expq.push_back(e); n++;
            end else begin
                for (int k = 0; k < nb; k++) begin
                    e = '0;
                    e.mwr = wr; e.chk_mem = 1'b1; e.maddr = addr + 32'(k); e.mop = 2'd0;
                    e.mext = 1'b0; e.mwdata = (wd >> (8 * k)) & 32'hFF;
                    expq.push_back(e); n++;
                end
            end
            if (wr) for (int k = 0; k < nb; k++) ref_mem[addr + 32'(k)] = wd[8*k +: 8];
        end
        e = '0;
        e.rv = 1'b1; e.err = err; e.rdata = (err || wr) ? 32'h0 : val;
        expq.push_back(e); n++;
        e = '0;
        e.ready = 1'b1;
        expq.push_back(e); n++;
    endtask

    // Drive one request from a negedge in IDLE; returns at the negedge of the next IDLE cycle
    task automatic issue(input bit wr, input logic [1:0] op, input bit ext,
                         input logic [31:0] addr, input logic [31:0] wd, input bit hold);
        int n;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_op    = op;
        bus.req_ext   = ext;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        model(wr, op, ext, addr, wd, n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!hold || i >= n - 2) begin
                bus.req_valid = 1'b0;
            end else begin
                bus.req_addr  = $urandom;
                bus.req_wdata = $urandom;
                bus.req_wr    = ~bus.req_wr;
            end
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            dmem[a + 32'(k)]    = w[8*k +: 8];
            ref_mem[a + 32'(k)] = w[8*k +: 8];
        end
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        int          w0;
        int          r0;
        logic [31:0] a;
        logic [1:0]  op;

        clk = 1'b0; rst = 1'b1;
        n_chk = 0; n_err = 0; wr_cycles = 0; resp_cnt = 0;
        last_rdata = '0; last_err = 1'b0; pend_wr = 1'b0;
        pend_addr = '0; pend_op = '0; pend_wdata = '0;
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_op = 2'd0; bus.req_ext = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.mem_rdata = '0;

        preload(32'h1001_0004, 32'h80FF_7F01);
        preload(32'h1001_0008, 32'h4433_2211);
        preload(32'h1001_000C, 32'h8877_6655);

        // Reset state
        @(negedge clk);
        chk("rst_ready",      32'(bus.req_ready),  32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,      32'd0);
        chk("rst_mem_wr",     32'(bus.mem_wr),     32'd0);
        chk("rst_mem_addr",   bus.mem_addr,        32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Aligned word store then load
        w0 = wr_cycles;
        issue(1'b1, 2'd2, 1'b0, 32'h1001_0000, 32'hDEAD_BEEF, 1'b0);
        chk("store_wr_cycles", 32'(wr_cycles - w0), 32'd1);
        issue(1'b0, 2'd2, 1'b0, 32'h1001_0000, 32'h0, 1'b0);
        chk("load_word", last_rdata, 32'hDEAD_BEEF);

        // Byte loads with extension
        issue(1'b0, 2'd0, 1'b1, 32'h1001_0006, 32'h0, 1'b0);
        chk("lb_signed_ff", last_rdata, 32'hFFFF_FFFF);
        issue(1'b0, 2'd0, 1'b0, 32'h1001_0006, 32'h0, 1'b0);
        chk("lbu_ff", last_rdata, 32'h0000_00FF);
        issue(1'b0, 2'd0, 1'b1, 32'h1001_0007, 32'h0, 1'b0);
        chk("lb_signed_80", last_rdata, 32'hFFFF_FF80);

`ifdef LSU_MISALIGN_SPLIT_EN
        // Split accesses
        issue(1'b0, 2'd1, 1'b1, 32'h1001_0009, 32'h0, 1'b0);
        chk("split_half", last_rdata, 32'h0000_3322);
        issue(1'b0, 2'd2, 1'b1, 32'h1001_000B, 32'h0, 1'b0);
        chk("split_word", last_rdata, 32'h7766_5544);
        w0 = wr_cycles;
        issue(1'b1, 2'd2, 1'b0, 32'h1001_0011, 32'hCAFE_BABE, 1'b0);
        chk("split_store_wr_cycles", 32'(wr_cycles - w0), 32'd4);
        issue(1'b0, 2'd2, 1'b0, 32'h1001_0010, 32'h0, 1'b0);
        chk("split_store_lo", last_rdata, 32'hFEBA_BE00);
        issue(1'b0, 2'd2, 1'b0, 32'h1001_0014, 32'h0, 1'b0);
        chk("split_store_hi", last_rdata, 32'h0000_00CA);
`else
        // Misaligned rejection
        w0 = wr_cycles;
        issue(1'b1, 2'd2, 1'b0, 32'h1001_0002, 32'h1234_5678, 1'b0);
        chk("reject_err", 32'(last_err), 32'd1);
        chk("reject_wr_cycles", 32'(wr_cycles - w0), 32'd0);
        issue(1'b0, 2'd2, 1'b0, 32'h1001_0000, 32'h0, 1'b0);
        chk("reject_mem_intact", last_rdata, 32'hDEAD_BEEF);
`endif

        // Unused size encoding
        issue(1'b0, 2'd3, 1'b0, 32'h1001_0000, 32'h0, 1'b0);
        chk("op11_err",   32'(last_err), 32'd1);
        chk("op11_rdata", last_rdata,    32'd0);

        // Reset in the middle of a store
        r0 = resp_cnt;
        bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_op = 2'd2; bus.req_ext = 1'b0;
        bus.req_wdata = 32'h1122_3344;
`ifdef LSU_MISALIGN_SPLIT_EN
        bus.req_addr = 32'h1001_0021;
        @(posedge clk);
        @(negedge clk); bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
`else
        bus.req_addr = 32'h1001_0020;
        @(posedge clk);
`endif
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready",      32'(bus.req_ready),  32'd1);
        chk("midrst_mem_wr",     32'(bus.mem_wr),     32'd0);
        chk("midrst_mem_addr",   bus.mem_addr,        32'd0);
        chk("midrst_mem_wdata",  bus.mem_wdata,       32'd0);
        chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", 32'(bus.req_ready), 32'd1);
        chk("midrst_no_resp",     32'(resp_cnt - r0), 32'd0);
`ifdef LSU_MISALIGN_SPLIT_EN
        ref_mem[32'h1001_0021] = 8'h44;
        ref_mem[32'h1001_0022] = 8'h33;
        issue(1'b0, 2'd2, 1'b0, 32'h1001_0020, 32'h0, 1'b0);
        chk("midrst_partial", last_rdata, 32'h0033_4400);
`else
        issue(1'b0, 2'd2, 1'b0, 32'h1001_0020, 32'h0, 1'b0);
        chk("midrst_partial", last_rdata, 32'h0000_0000);
`endif
        issue(1'b0, 2'd2, 1'b0, 32'h1001_0024, 32'h0, 1'b0);
        chk("midrst_untouched", last_rdata, 32'h0000_0000);

        // req_valid held through the access: exactly one request accepted
        r0 = resp_cnt;
        issue(1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'h0, 1'b1);
        chk("hold_one_resp", 32'(resp_cnt - r0), 32'd1);
        chk("hold_rdata",    last_rdata,         32'h4433_2211);

        // Randomized traffic, including accesses that wrap past the top of memory
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                           a = 32'h1001_0040 + 32'($urandom_range(0, 63));
            op = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)), a, $urandom,
                  ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) @(negedge clk);
            end
        end

        @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the pipeline memory stage and the byte-addressed data memory.
- Accepts one load or store request at a time over a valid/ready handshake and drives the memory port: write strobe, size op, extension select, address and write data.
- Returns load data with a one-cycle response pulse.
- Misaligned half/word accesses are either split into sequential byte accesses or rejected, selected by build option.

Parameters:
- ADDR_W, 32, request/memory address width
- DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_wr  in  1  1 = store, 0 = load
- req_op  in  2  size: MEM_BYTE / MEM_HALF / MEM_WORD, using the shared encode header values
- req_ext  in  1  load extension: 1 = signed, 0 = zero
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse when the request completes
- resp_rdata  out  32  load result, extended; 0 for stores
- resp_err  out  1  valid with resp_valid; misaligned request rejected
- mem_wr  out  1  memory write strobe; memory commits at the rising edge
- mem_op  out  2  memory size op
- mem_ext  out  1  memory extension select
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  combinational memory read data for the current mem_addr/mem_op/mem_ext

Behaviour:
- Reset (asynchronous, immediate): state IDLE, req_ready = 1; all other outputs 0, including mem_wr. All internal registers cleared.
- Handshake:
  - req_ready = 1 only in IDLE.
  - Accept on a rising edge with req_valid & req_ready; latch wr/op/ext/addr/wdata.
  - Request inputs are ignored outside IDLE.
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
  - RESP always lasts exactly 1 cycle.
  - A new request may be accepted in the IDLE cycle immediately after RESP. Back-to-back throughput is therefore one request per 3 cycles for aligned accesses.
- Alignment:
  - byte: always aligned
  - half: aligned when addr[0] = 0
  - word: aligned when addr[1:0] = 0
  - req_op = 2'b11 (unused encoding): treated as misaligned; resp_err = 1, no memory access.
- Aligned access:
  - ACCESS lasts 1 cycle, driving mem_op = req_op, mem_ext = req_ext, mem_addr = addr, mem_wdata = wdata, mem_wr = wr.
  - For loads, mem_rdata is captured at the end of ACCESS.
  - Latency: accept edge T, memory cycle T+1, resp_valid high during cycle T+2.
- Misaligned access, split mode:
  - ACCESS lasts N cycles (N = 2 for half, 4 for word), with byte counter k = 0..N-1.
  - Each cycle drives mem_op = MEM_BYTE, mem_ext = 0, mem_addr = addr + k (mod 2^32, wraps past 0xFFFFFFFF).
  - Store: mem_wdata[7:0] = wdata[8k+7:8k], upper bits 0, mem_wr = 1 each cycle.
  - Load: byte k = mem_rdata[7:0], placed at result[8k+7:8k], little-endian.
  - After the last byte, half results are sign- or zero-extended from bit 15 per req_ext.
- Outside ACCESS, mem_wr = 0. The other mem_* outputs hold their last values (don't-care to memory).
- resp_rdata holds its value until the next RESP. It is 0 for stores and errored requests.
- Reset mid-ACCESS: FSM aborts to IDLE with no response. Bytes already written stay committed.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned half/word requests use split mode (above); resp_err is only set for op 2'b11.
- Undefined: misaligned requests skip ACCESS and go IDLE -> RESP; resp_valid = 1, resp_err = 1, resp_rdata = 0, no memory write. Latency is 1 cycle after accept.

Test Plan:
- Aligned word store then load:
  - store 0xDEADBEEF to 0x10010000; expect mem_wr high for exactly 1 cycle.
  - load word from 0x10010000; expect resp_rdata = 0xDEADBEEF, resp_valid high 2 cycles after accept.
- Byte load with extension, memory word 0x80FF7F01 at 0x10010004:
  - load byte from 0x10010006: signed -> 0xFFFFFFFF, unsigned -> 0x000000FF.
  - load byte from 0x10010007 signed -> 0xFFFFFF80.
- Split half load, with LSU_MISALIGN_SPLIT_EN defined, memory words 0x44332211 at 0x10010008 and 0x88776655 at 0x1001000C:
  - signed half load from 0x10010009 -> 2 byte accesses, resp_rdata = 0x00003322.
  - signed word load from 0x1001000B -> 4 byte accesses at +0..+3, resp_rdata = 0x77665544.
- Split word store:
  - store 0xCAFEBABE to 0x10010011; expect 4 mem_wr cycles with addresses 0x10010011..0x10010014 and bytes 0xBE, 0xBA, 0xFE, 0xCA.
  - aligned reads of 0x10010010 and 0x10010014 confirm placement.
- Rejection, macro undefined:
  - word store to 0x10010002 -> resp_err = 1 one cycle after accept, mem_wr never asserted, memory unchanged.
  - op 2'b11 with macro defined -> resp_err = 1.
- Reset and handshake:
  - assert rst during byte 2 of a split word store -> all outputs 0 immediately, req_ready = 1 after release, bytes 0-1 written, bytes 2-3 unchanged.
  - req_valid held high through ACCESS -> only one request accepted.
